encode_stream: RTL and testbench

ENCODE_STREAM -- requirements
Module: encode_stream

---
 rtl/encode_stream_pkg.sv | 10 +
 rtl/encode_stream_prio_enc.sv | 23 ++
 rtl/encode_stream.sv | 86 ++++++++
 tb/tb_encode_stream.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/encode_stream_pkg.sv
// Shared types for the set-bit stream encoder.
// Holds the FSM state enum used by encode_stream.
package encode_stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/encode_stream_prio_enc.sv
// Combinational lowest-set-bit finder.
// Ports: vec (in), idx (lowest set bit index), found (vec != 0).
module prio_enc #(
  parameter int W = 4
) (
  input  logic [(1<<W)-1:0] vec,
  output logic [W-1:0]      idx,
  output logic              found
);

  // Scan high to low so the lowest set bit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = (1<<W)-1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encode_stream.sv
// Emits the indices of the set bits of each accepted vector, lowest first.
// Ports: clk, rst_n, in_valid/in_ready/in_vec, out_valid/out_ready,
// out_idx, out_last, busy; out_onehot with ENCODE_STREAM_ONEHOT_EN.
module encode_stream
  import encode_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [(1<<DATA_WIDTH)-1:0] in_vec,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_idx,
  output logic                       out_last,
`ifdef ENCODE_STREAM_ONEHOT_EN
  output logic [(1<<DATA_WIDTH)-1:0] out_onehot,
`endif
  output logic                       busy
);

  localparam int VW = 1 << DATA_WIDTH;

  state_t          state;
  state_t          state_nx;
  logic [VW-1:0]   pending;
  logic [VW-1:0]   pending_nx;
  logic [DATA_WIDTH-1:0] low_idx;
  logic            found;
  logic            single;
  logic            fire_out;
  logic            accept;

  prio_enc #(
    .W (DATA_WIDTH)
  ) u_prio (
    .vec   (pending),
    .idx   (low_idx),
    .found (found)
  );

  // x & (x-1) clears the lowest set bit; zero result means one bit left.
  assign single    = found && ((pending & (pending - 1'b1)) == '0);

  assign busy      = (state == BUSY);
  assign out_valid = busy;
  assign out_idx   = busy ? low_idx : '0;
  assign out_last  = busy && single;
  assign fire_out  = out_valid && out_ready;
  assign in_ready  = !busy || (fire_out && out_last);
  assign accept    = in_valid && in_ready;

`ifdef ENCODE_STREAM_ONEHOT_EN
  always_comb begin
    out_onehot = '0;
    if (out_valid) out_onehot[low_idx] = 1'b1;
  end
`endif

  always_comb begin
    state_nx   = state;
    pending_nx = pending;
    if (fire_out) begin
      pending_nx = pending & (pending - 1'b1);
      if (out_last) state_nx = IDLE;
    end
    // A zero vector is dropped; pending is already empty here.
    if (accept && (in_vec != '0)) begin
      pending_nx = in_vec;
      state_nx   = BUSY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_nx;
      pending <= pending_nx;
    end
  end

endmodule

// File: tb/tb_encode_stream.sv
// Directed self-checking bench for encode_stream (DATA_WIDTH=4).
// Define ENCODE_STREAM_ONEHOT_EN to also exercise out_onehot.
module tb_encode_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_vec;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_idx;
  logic        out_last;
  logic        busy;
`ifdef ENCODE_STREAM_ONEHOT_EN
  logic [15:0] out_onehot;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  encode_stream #(
    .DATA_WIDTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vec     (in_vec),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_last   (out_last),
`ifdef ENCODE_STREAM_ONEHOT_EN
    .out_onehot (out_onehot),
`endif
    .busy       (busy)
  );

  // Offer a vector for one cycle; returns at the next negedge
  // with in_valid dropped, i.e. where the first beat is visible.
  task automatic offer(input logic [15:0] v);
    @(negedge clk);
    in_valid = 1'b1;
    in_vec   = v;
    @(negedge clk);
    in_valid = 1'b0;
    in_vec   = '0;
    #1;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b0;
    #12;
    checks++;
    if ({out_valid, in_ready, busy, out_last, out_idx} !== 8'b0_1_0_0_0000) begin
      errors++;
      $display("FAIL reset got v=%b r=%b b=%b l=%b i=%0d want 0 1 0 0 0",
               out_valid, in_ready, busy, out_last, out_idx);
    end
`ifdef ENCODE_STREAM_ONEHOT_EN
    checks++;
    if (out_onehot !== 16'h0000) begin
      errors++;
      $display("FAIL reset_onehot got %h want 0000", out_onehot);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_vec   = 16'h0000;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_ready got %b want 1", in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL zero_idle c%0d got v=%b r=%b want v=0 r=1",
                 k, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_stream;
    logic [3:0] exp [4] = '{4'd0, 4'd5, 4'd10, 4'd15};
    out_ready = 1'b1;
    offer(16'h8421);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== exp[k] ||
          out_last !== (k == 3) || in_ready !== (k == 3) ||
          busy !== 1'b1) begin
        errors++;
        $display("FAIL stream b%0d got v=%b i=%0d l=%b r=%b want 1 %0d %b %b",
                 k, out_valid, out_idx, out_last, in_ready,
                 exp[k], (k == 3), (k == 3));
      end
      @(negedge clk);
      #1;
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stream_end got v=%b r=%b b=%b want 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_stall;
    out_ready = 1'b0;
    offer(16'h0110);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 4'd4 || out_last !== 1'b0 ||
          in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall c%0d got v=%b i=%0d l=%b r=%b want 1 4 0 0",
                 k, out_valid, out_idx, out_last, in_ready);
      end
      @(negedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_idx !== 4'd4 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL stall_rel0 got i=%0d l=%b want 4 0", out_idx, out_last);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 4'd8 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL stall_rel1 got v=%b i=%0d l=%b want 1 8 1",
               out_valid, out_idx, out_last);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_end got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    offer(16'h0001);
    in_valid = 1'b1;
    in_vec   = 16'h0002;
    #1;
    checks++;
    if (out_idx !== 4'd0 || out_last !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first got i=%0d l=%b r=%b want 0 1 1",
               out_idx, out_last, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_vec   = '0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 4'd1 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second got v=%b i=%0d l=%b want 1 1 1",
               out_valid, out_idx, out_last);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end got v=%b r=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    offer(16'hFFFF);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 4'(k)) begin
        errors++;
        $display("FAIL rmid_beat b%0d got v=%b i=%0d want 1 %0d",
                 k, out_valid, out_idx, k);
      end
      @(negedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, busy, out_last, out_idx} !== 8'b0_1_0_0_0000) begin
      errors++;
      $display("FAIL rmid_reset got v=%b r=%b b=%b l=%b i=%0d want 0 1 0 0 0",
               out_valid, in_ready, busy, out_last, out_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rmid_after c%0d got v=%b r=%b want 0 1",
                 k, out_valid, in_ready);
      end
    end
  endtask

`ifdef ENCODE_STREAM_ONEHOT_EN
  task automatic test_onehot;
    out_ready = 1'b1;
    offer(16'h0024);
    checks++;
    if (out_onehot !== 16'h0004) begin
      errors++;
      $display("FAIL onehot0 got %h want 0004", out_onehot);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_onehot !== 16'h0020) begin
      errors++;
      $display("FAIL onehot1 got %h want 0020", out_onehot);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_onehot !== 16'h0000) begin
      errors++;
      $display("FAIL onehot_idle got %h want 0000", out_onehot);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_zero;
    test_stream;
    test_stall;
    test_back_to_back;
    test_reset_mid;
`ifdef ENCODE_STREAM_ONEHOT_EN
    test_onehot;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
